// File: rtl/spi_frame_controller.sv
// spi_frame_controller: deframes the local SPI byte stream into a device
// address, a register index and data bytes. It drives the register file
// strobes, shifts read data out on MISO, and holds the programmable
// daisy-chain device address.
module spi_frame_controller #(
    parameter logic [6:0] DEFAULT_ADDR = 7'h7F,
    parameter logic [7:0] ADDR_REG     = 8'hFE
) (
    input  logic       SPI_CLK,
    input  logic       RSTin,
    input  logic       sclk_local,
    input  logic       scsn_local,
    input  logic       mosi_local,
    output logic       miso_local,
    output logic       address_strobe,
    output logic [6:0] currentSPIAddr,
    output logic [6:0] setSPIAddr,
    input  logic       write_enable,
    output logic [7:0] reg_addr,
    output logic [7:0] wr_data,
    output logic       wr_strobe,
    output logic       rd_strobe,
    input  logic [7:0] rd_data
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_INDEX = 2'd2,
        ST_DATA  = 2'd3
    } state_t;

    // Pin synchronisers: two metastability flops plus one history flop each
    logic r_sclk_s1;
    logic r_sclk_s2;
    logic r_sclk_d;
    logic r_scsn_s1;
    logic r_scsn_s2;
    logic r_scsn_d;
    logic r_mosi_s1;
    logic r_mosi_s2;
    logic r_mosi_d;

    // Frame state
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [BYTE_W-2:0] r_shift_in;
    logic              r_rw;
    logic [BYTE_W-1:0] r_index;

    // Read path
    logic              r_rd_pending;
    logic [BYTE_W-1:0] r_shreg;

    // Decoded events
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_scsn_rise;
    logic              w_scsn_fall;
    logic              w_bit_en;
    logic              w_byte_done;
    logic [BYTE_W-1:0] w_byte;
    logic [BYTE_W-1:0] w_index_inc;
    logic              w_addr_done;
    logic              w_index_done;
    logic              w_data_done;

    // Synchronise the asynchronous SPI pins into the SPI_CLK domain.
    // scsn resets low so a frame already in progress at reset release
    // shows no falling edge and is ignored until the next real scsn fall.
    always_ff @(posedge SPI_CLK) begin
        if (RSTin) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_scsn_s1 <= 1'b0;
            r_scsn_s2 <= 1'b0;
            r_scsn_d  <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_mosi_d  <= 1'b0;
        end else begin
            r_sclk_s1 <= sclk_local;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_scsn_s1 <= scsn_local;
            r_scsn_s2 <= r_scsn_s1;
            r_scsn_d  <= r_scsn_s2;
            r_mosi_s1 <= mosi_local;
            r_mosi_s2 <= r_mosi_s1;
            r_mosi_d  <= r_mosi_s2;
        end
    end

    // Edge detection and per-bit qualifiers
    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
    assign w_scsn_rise = r_scsn_s2 & ~r_scsn_d;
    assign w_scsn_fall = ~r_scsn_s2 & r_scsn_d;

    // A bit is taken only while selected; a scsn rise implies scsn high, so
    // it always beats a coincident sclk rise.
    assign w_bit_en    = w_sclk_rise & ~r_scsn_s2 & (r_state != ST_IDLE);
    assign w_byte_done = w_bit_en & (r_bit_cnt == LAST_BIT);
    // MOSI is taken from the history flop, aligned with the pre-edge sclk sample
    assign w_byte      = {r_shift_in, r_mosi_d};
    assign w_index_inc = r_index + BYTE_W'(1);

    // FSM state register
    always_ff @(posedge SPI_CLK) begin
        if (RSTin) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and byte-completion decode
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_done  = 1'b0;
        w_index_done = 1'b0;
        w_data_done  = 1'b0;
        if (w_scsn_rise) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_scsn_fall) begin
                        w_state_nxt = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_byte_done) begin
                        w_addr_done = 1'b1;
                        w_state_nxt = ST_INDEX;
                    end
                end
                ST_INDEX: begin
                    if (w_byte_done) begin
                        w_index_done = 1'b1;
                        w_state_nxt  = ST_DATA;
                    end
                end
                ST_DATA: begin
                    w_data_done = w_byte_done;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Bit counter and MOSI byte assembly; frame edges discard any partial byte
    always_ff @(posedge SPI_CLK) begin
        if (RSTin) begin
            r_bit_cnt  <= '0;
            r_shift_in <= '0;
        end else if (w_scsn_rise || w_scsn_fall) begin
            r_bit_cnt  <= '0;
        end else if (w_bit_en) begin
            r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
            r_shift_in <= w_byte[BYTE_W-2:0];
        end
    end

    // Frame decode: address latch, index tracking and register strobes
    always_ff @(posedge SPI_CLK) begin
        if (RSTin) begin
            r_rw           <= 1'b0;
            r_index        <= '0;
            currentSPIAddr <= '0;
            setSPIAddr     <= DEFAULT_ADDR;
            reg_addr       <= '0;
            wr_data        <= '0;
            address_strobe <= 1'b0;
            wr_strobe      <= 1'b0;
            rd_strobe      <= 1'b0;
        end else begin
            address_strobe <= w_addr_done;
            wr_strobe      <= 1'b0;
            rd_strobe      <= 1'b0;

            // Direction is unknown until the address byte lands
            if (w_scsn_fall) begin
                r_rw <= 1'b0;
            end

            if (w_addr_done) begin
                currentSPIAddr <= w_byte[ADDR_W-1:0];
                r_rw           <= w_byte[BYTE_W-1];
            end

            if (w_index_done) begin
                r_index <= w_byte;
                if (r_rw) begin
                    rd_strobe <= 1'b1;
                    reg_addr  <= w_byte;
                end
            end

            if (w_data_done) begin
                r_index <= w_index_inc;
                if (r_rw) begin
                    // Prefetch the next register for the following byte
                    rd_strobe <= 1'b1;
                    reg_addr  <= w_index_inc;
                end else if (write_enable) begin
                    wr_strobe <= 1'b1;
                    reg_addr  <= r_index;
                    wr_data   <= w_byte;
                    if (r_index == ADDR_REG) begin
                        setSPIAddr <= w_byte[ADDR_W-1:0];
                    end
                end
            end
        end
    end

    // MISO shift register: load the cycle after a read strobe, shift on sclk
    // falls except the one at a byte boundary so the MSB covers bit 0.
    always_ff @(posedge SPI_CLK) begin
        if (RSTin) begin
            r_rd_pending <= 1'b0;
            r_shreg      <= '0;
        end else begin
            r_rd_pending <= rd_strobe;
            if (r_rd_pending) begin
                r_shreg <= rd_data;
            end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
                r_shreg <= {r_shreg[BYTE_W-2:0], 1'b0};
            end
        end
    end

    // MISO is driven only inside a read frame
    assign miso_local = r_shreg[BYTE_W-1] & r_rw & (r_state != ST_IDLE);

endmodule
